axi4_line_master: RTL

//  AXI4 initiator. Turns one cache-line request from the core side into a single INCR burst.
//  A read request becomes an AR burst plus the R beats; a write request becomes AW, W beats and B.
//  It drives the sim_periph / memory-side AXI responders. It returns the assembled line and an

---
 rtl/axi4_line_master_if.sv | 105 ++++++++++
 rtl/axi4_line_master.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axi4_line_master_if.sv
// Core-side line request/response channels plus the full AXI4 master bus for axi4_line_master.
// Latency: none; pure signal bundle.
// Backpressure: valid/ready on every channel; the master modport faces the initiator.
interface axi4_line_master_if #(
   parameter int AXI_ADDR_W = 64,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 64,
   parameter int BURST_LEN  = 4
);
   localparam int LINE_W = BURST_LEN * AXI_DATA_W;

   // core-side request / response
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wen;
   logic [AXI_ADDR_W-1:0] req_addr;
   logic [LINE_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_err;
   logic [LINE_W-1:0]     rsp_rdata;

   // write address
   logic                  axi_awvalid;
   logic                  axi_awready;
   logic [AXI_ADDR_W-1:0] axi_awaddr;
   logic [7:0]            axi_awlen;
   logic [2:0]            axi_awsize;
   logic [1:0]            axi_awburst;
   logic [AXI_ID_W-1:0]   axi_awid;
   logic                  axi_awlock;
   logic [3:0]            axi_awcache;
   logic [2:0]            axi_awprot;
   logic [3:0]            axi_awqos;
   logic [3:0]            axi_awregion;

   // write data
   logic                    axi_wvalid;
   logic                    axi_wready;
   logic                    axi_wlast;
   logic [AXI_DATA_W-1:0]   axi_wdata;
   logic [AXI_DATA_W/8-1:0] axi_wstrb;

   // write response
   logic                  axi_bvalid;
   logic                  axi_bready;
   logic [AXI_ID_W-1:0]   axi_bid;
   logic [1:0]            axi_bresp;

   // read address
   logic                  axi_arvalid;
   logic                  axi_arready;
   logic [AXI_ADDR_W-1:0] axi_araddr;
   logic [7:0]            axi_arlen;
   logic [2:0]            axi_arsize;
   logic [1:0]            axi_arburst;
   logic [AXI_ID_W-1:0]   axi_arid;
   logic                  axi_arlock;
   logic [3:0]            axi_arcache;
   logic [2:0]            axi_arprot;
   logic [3:0]            axi_arqos;
   logic [3:0]            axi_arregion;

   // read data
   logic                  axi_rvalid;
   logic                  axi_rready;
   logic [AXI_ID_W-1:0]   axi_rid;
   logic [1:0]            axi_rresp;
   logic [AXI_DATA_W-1:0] axi_rdata;
   logic                  axi_rlast;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_err, rsp_rdata,
      output axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
      output axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awregion,
      input  axi_awready,
      output axi_wvalid, axi_wlast, axi_wdata, axi_wstrb,
      input  axi_wready,
      output axi_bready,
      input  axi_bvalid, axi_bid, axi_bresp,
      output axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid,
      output axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion,
      input  axi_arready,
      output axi_rready,
      input  axi_rvalid, axi_rid, axi_rresp, axi_rdata, axi_rlast
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata,
      input  axi_awvalid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awid,
      input  axi_awlock, axi_awcache, axi_awprot, axi_awqos, axi_awregion,
      output axi_awready,
      input  axi_wvalid, axi_wlast, axi_wdata, axi_wstrb,
      output axi_wready,
      input  axi_bready,
      output axi_bvalid, axi_bid, axi_bresp,
      input  axi_arvalid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid,
      input  axi_arlock, axi_arcache, axi_arprot, axi_arqos, axi_arregion,
      output axi_arready,
      input  axi_rready,
      output axi_rvalid, axi_rid, axi_rresp, axi_rdata, axi_rlast
   );
endinterface

// File: rtl/axi4_line_master.sv
// AXI4 initiator: one cache-line request becomes one INCR burst (AR+R or AW+W+B), one in flight.
// Latency: zero-wait read = accept + AR + BURST_LEN beats before rsp_valid; write = accept + AW + BURST_LEN + B.
// Backpressure: every AXI valid holds until its ready; rsp_valid/data hold until rsp_ready; req_ready only in IDLE.
module axi4_line_master #(
   parameter int AXI_ADDR_W = 64,
   parameter int AXI_ID_W   = 8,
   parameter int AXI_DATA_W = 64,
   parameter int BURST_LEN  = 4,
   parameter int MST_ID     = 0
) (
   input  logic               aclk,
   input  logic               arst_n,
   axi4_line_master_if.master bus
);
   localparam int LINE_W     = BURST_LEN * AXI_DATA_W;
   localparam int LINE_BYTES = LINE_W / 8;

   localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~(AXI_ADDR_W'(LINE_BYTES - 1));
   localparam logic [7:0]            LAST_BEAT = 8'(BURST_LEN - 1);
   localparam logic [2:0]            AX_SIZE   = 3'($clog2(AXI_DATA_W / 8));
   localparam logic [AXI_ID_W-1:0]   ID        = AXI_ID_W'(MST_ID);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_AR   = 3'd1;
   localparam logic [2:0] S_R    = 3'd2;
   localparam logic [2:0] S_AW   = 3'd3;
   localparam logic [2:0] S_W    = 3'd4;
   localparam logic [2:0] S_B    = 3'd5;
   localparam logic [2:0] S_RSP  = 3'd6;

   logic [2:0]            state;
   logic [AXI_ADDR_W-1:0] addr_q;
   logic [LINE_W-1:0]     wdata_q;
   logic [LINE_W-1:0]     rdata_q;
   logic                  err_q;
   logic [7:0]            beat_cnt;
   logic [AXI_DATA_W-1:0] wbeat;

   // Transaction sequencing, beat counting, read-line assembly and error accumulation
   always_ff @(posedge aclk or negedge arst_n) begin
      if (!arst_n) begin
         state    <= S_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         beat_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: if (bus.req_valid) begin
               addr_q   <= bus.req_addr & ADDR_MASK;
               wdata_q  <= bus.req_wdata;
               err_q    <= 1'b0;
               beat_cnt <= '0;
               state    <= bus.req_wen ? S_AW : S_AR;
            end
            S_AR: if (bus.axi_arready) state <= S_R;
            S_R: if (bus.axi_rvalid) begin
               beat_cnt <= beat_cnt + 8'd1;
               // the final slot only takes the beat that really closes the burst
               for (int k = 0; k < BURST_LEN; k++) begin
                  if (beat_cnt == 8'(k) && (bus.axi_rlast || beat_cnt != LAST_BEAT))
                     rdata_q[k*AXI_DATA_W +: AXI_DATA_W] <= bus.axi_rdata;
               end
               err_q <= err_q | (bus.axi_rresp != 2'b00) | (bus.axi_rid != ID) |
                        (bus.axi_rlast ? (beat_cnt != LAST_BEAT) : (beat_cnt == LAST_BEAT));
               if (bus.axi_rlast) state <= S_RSP;
            end
            S_AW: if (bus.axi_awready) state <= S_W;
            S_W: if (bus.axi_wready) begin
               beat_cnt <= beat_cnt + 8'd1;
               if (beat_cnt == LAST_BEAT) state <= S_B;
            end
            S_B: if (bus.axi_bvalid) begin
               err_q <= err_q | (bus.axi_bresp != 2'b00) | (bus.axi_bid != ID);
               state <= S_RSP;
            end
            S_RSP: if (bus.rsp_ready) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Select the latched write beat addressed by the beat counter
   always_comb begin
      wbeat = '0;
      for (int k = 0; k < BURST_LEN; k++) begin
         if (beat_cnt == 8'(k)) wbeat = wdata_q[k*AXI_DATA_W +: AXI_DATA_W];
      end
   end

   assign bus.req_ready = (state == S_IDLE);
   assign bus.rsp_valid = (state == S_RSP);
   assign bus.rsp_err   = err_q;
   assign bus.rsp_rdata = rdata_q;

   assign bus.axi_awvalid  = (state == S_AW);
   assign bus.axi_awaddr   = addr_q;
   assign bus.axi_awlen    = LAST_BEAT;
   assign bus.axi_awsize   = AX_SIZE;
   assign bus.axi_awburst  = 2'b01;
   assign bus.axi_awid     = ID;
   assign bus.axi_awlock   = 1'b0;
   assign bus.axi_awcache  = 4'd0;
   assign bus.axi_awprot   = 3'd0;
   assign bus.axi_awqos    = 4'd0;
   assign bus.axi_awregion = 4'd0;

   assign bus.axi_wvalid = (state == S_W);
   assign bus.axi_wlast  = (beat_cnt == LAST_BEAT);
   assign bus.axi_wdata  = wbeat;
   assign bus.axi_wstrb  = '1;
   assign bus.axi_bready = (state == S_B);

   assign bus.axi_arvalid  = (state == S_AR);
   assign bus.axi_araddr   = addr_q;
   assign bus.axi_arlen    = LAST_BEAT;
   assign bus.axi_arsize   = AX_SIZE;
   assign bus.axi_arburst  = 2'b01;
   assign bus.axi_arid     = ID;
   assign bus.axi_arlock   = 1'b0;
   assign bus.axi_arcache  = 4'd0;
   assign bus.axi_arprot   = 3'd0;
   assign bus.axi_arqos    = 4'd0;
   assign bus.axi_arregion = 4'd0;
   assign bus.axi_rready   = (state == S_R);
endmodule
